// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - instruction fetch program counter with memory handshake
// Optional FETCH_PC_WRAP_TRAP_EN: trap on pc wrap instead of silent rollover.
module fetch_pc #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              trap
);

`ifdef FETCH_PC_WRAP_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_t;
`endif

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [DATA_W-1:0] instr_q, instr_next;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_next;
`ifdef FETCH_PC_WRAP_TRAP_EN
  logic              trap_q, trap_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_VEC;
      instr_q    <= '0;
      instr_pc_q <= '0;
`ifdef FETCH_PC_WRAP_TRAP_EN
      trap_q     <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      instr_q    <= instr_next;
      instr_pc_q <= instr_pc_next;
`ifdef FETCH_PC_WRAP_TRAP_EN
      trap_q     <= trap_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    instr_next    = instr_q;
    instr_pc_next = instr_pc_q;
`ifdef FETCH_PC_WRAP_TRAP_EN
    trap_next     = trap_q;
`endif
    case (state)
      S_IDLE: begin
        state_next = S_REQ;
        if (branch_en) pc_next = branch_addr;
      end
      S_REQ: begin
        // A redirect wins over a coinciding ack; the returned word is dropped.
        if (branch_en) begin
          pc_next = branch_addr;
        end else if (mem_ack) begin
          instr_next    = mem_rdata;
          instr_pc_next = pc;
          pc_next       = pc + 1'b1;
          state_next    = S_VALID;
`ifdef FETCH_PC_WRAP_TRAP_EN
          if (pc == '1) trap_next = 1'b1;
`endif
        end
      end
      S_VALID: begin
        if (branch_en) begin
          pc_next    = branch_addr;
          state_next = S_REQ;
        end else if (instr_ready) begin
          state_next = S_REQ;
        end
`ifdef FETCH_PC_WRAP_TRAP_EN
        // The wrapped instruction is still delivered, then fetching stops for good.
        if (trap_q) begin
          pc_next    = pc;
          state_next = instr_ready ? S_TRAP : S_VALID;
        end
`endif
      end
`ifdef FETCH_PC_WRAP_TRAP_EN
      S_TRAP: begin
        state_next = S_TRAP;
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign fetch_req   = (state == S_REQ);
  assign instr_valid = (state == S_VALID);
  assign fetch_addr  = pc;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
`ifdef FETCH_PC_WRAP_TRAP_EN
  assign trap        = trap_q;
`else
  assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - scoreboard bench for fetch_pc
// Memory model pushes expected {instr, pc} on each accepted ack; tests pop on instr_valid.
module tb_fetch_pc;
  logic        clk = 1'b0;
  logic        rst_n, branch_en, fetch_req, mem_ack, instr_valid, instr_ready, trap;
  logic [15:0] branch_addr, fetch_addr, mem_rdata, instr, instr_pc;

  int          total = 0;
  int          bad = 0;
  logic        mem_auto = 1'b0;
  logic        force_ack = 1'b0;
  int          stall_cycles = 0;
  int          wait_cnt = 0;
  logic [31:0] exp_q[$];

  fetch_pc dut (
    .clk(clk), .rst_n(rst_n), .branch_en(branch_en), .branch_addr(branch_addr),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .trap(trap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a ^ 16'h5A5A) + 16'h1357;
  endfunction

  // Memory responds on the falling edge so its decisions never race the tests.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      if (force_ack) begin
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
      end else if (mem_auto && rst_n && fetch_req) begin
        if (wait_cnt < stall_cycles) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          mem_ack = 1'b1;
          mem_rdata = mem_fn(fetch_addr);
          if (!branch_en) exp_q.push_back({mem_rdata, fetch_addr});
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; branch_en = 1'b0; branch_addr = '0; instr_ready = 1'b0;
    mem_auto = 1'b0; force_ack = 1'b0; stall_cycles = 0;
    step(); step();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic goto_pc(input logic [15:0] a);
    branch_en = 1'b1; branch_addr = a;
    step();
    branch_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; branch_en = 1'b1; branch_addr = 16'h7777; instr_ready = 1'b1;
    step(); step();
    total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL reset_fetch_req got=%b exp=0", fetch_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
    total++; if (fetch_addr !== 16'h0000) begin bad++; $display("FAIL reset_fetch_addr got=%h exp=0000", fetch_addr); end
    total++; if (instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h exp=0000", instr); end
    total++; if (instr_pc !== 16'h0000) begin bad++; $display("FAIL reset_instr_pc got=%h exp=0000", instr_pc); end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL reset_trap got=%b exp=0", trap); end
    branch_en = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b1;
    step();
    total++; if (fetch_req !== 1'b1) begin bad++; $display("FAIL first_fetch_req got=%b exp=1", fetch_req); end
    total++; if (fetch_addr !== 16'h0000) begin bad++; $display("FAIL first_fetch_addr got=%h exp=0000", fetch_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    logic [15:0] exp_pc;
    apply_reset();
    stall_cycles = 1; instr_ready = 1'b1; mem_auto = 1'b1;
    exp_pc = 16'h0000;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 40 && instr_valid !== 1'b1; i++) step();
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_timeout got=%b exp=1", instr_valid); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      total++; if (instr !== e[31:16]) begin bad++; $display("FAIL seq_instr got=%h exp=%h", instr, e[31:16]); end
      total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL seq_instr_pc got=%h exp=%h", instr_pc, exp_pc); end
      exp_pc = exp_pc + 16'h1;
      step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    int held;
    apply_reset();
    goto_pc(16'h0010);
    stall_cycles = 3; instr_ready = 1'b0; mem_auto = 1'b1;
    held = 0;
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) begin
      if (fetch_req === 1'b1 && fetch_addr === 16'h0010) held++;
      step();
    end
    total++; if (held != 4) begin bad++; $display("FAIL stall_hold_cycles got=%0d exp=4", held); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", instr_valid); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    total++; if (instr !== mem_fn(16'h0010)) begin bad++; $display("FAIL stall_instr got=%h exp=%h", instr, mem_fn(16'h0010)); end
    total++; if (instr_pc !== e[15:0] || instr_pc !== 16'h0010) begin bad++; $display("FAIL stall_instr_pc got=%h exp=0010", instr_pc); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    logic [15:0] saved;
    apply_reset();
    goto_pc(16'h0020);
    stall_cycles = 0; instr_ready = 1'b0; mem_auto = 1'b1;
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    total++; if (instr !== e[31:16]) begin bad++; $display("FAIL bp_instr got=%h exp=%h", instr, e[31:16]); end
    saved = e[31:16];
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (instr_valid !== 1'b1 || fetch_req !== 1'b0 || instr !== saved || instr_pc !== 16'h0020) begin
        bad++; $display("FAIL bp_hold cycle=%0d got valid=%b req=%b instr=%h pc=%h exp 1 0 %h 0020", i, instr_valid, fetch_req, instr, instr_pc, saved);
      end
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0021) begin bad++; $display("FAIL bp_next_fetch got req=%b addr=%h exp 1 0021", fetch_req, fetch_addr); end
  endtask

  task automatic test_branch();
    logic [31:0] e;
    logic [15:0] saved;
    apply_reset();
    goto_pc(16'h0030);
    stall_cycles = 0; instr_ready = 1'b1; mem_auto = 1'b1;
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    total++; if (instr !== e[31:16] || instr_pc !== 16'h0030) begin bad++; $display("FAIL br_first got instr=%h pc=%h exp %h 0030", instr, instr_pc, e[31:16]); end
    saved = instr;
    step();
    total++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0031) begin bad++; $display("FAIL br_pre_fetch got req=%b addr=%h exp 1 0031", fetch_req, fetch_addr); end
    branch_en = 1'b1; branch_addr = 16'h1234;
    step();
    branch_en = 1'b0;
    total++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h1234 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL br_redirect got req=%b addr=%h valid=%b exp 1 1234 0", fetch_req, fetch_addr, instr_valid);
    end
    total++; if (instr !== saved) begin bad++; $display("FAIL br_discard got=%h exp=%h", instr, saved); end
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    total++; if (instr !== e[31:16] || instr_pc !== 16'h1234) begin bad++; $display("FAIL br_target got instr=%h pc=%h exp %h 1234", instr, instr_pc, e[31:16]); end
    branch_en = 1'b1; branch_addr = 16'h0050;
    step();
    branch_en = 1'b0;
    total++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0050 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL br_in_valid got req=%b addr=%h valid=%b exp 1 0050 0", fetch_req, fetch_addr, instr_valid);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    goto_pc(16'h0042);
    total++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0042) begin bad++; $display("FAIL rm_setup got req=%b addr=%h exp 1 0042", fetch_req, fetch_addr); end
    rst_n = 1'b0; force_ack = 1'b1;
    step(); step();
    total++; if (fetch_addr !== 16'h0000 || instr !== 16'h0000 || instr_pc !== 16'h0000) begin
      bad++; $display("FAIL rm_state got addr=%h instr=%h pc=%h exp 0000 0000 0000", fetch_addr, instr, instr_pc);
    end
    total++; if (fetch_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL rm_outputs got req=%b valid=%b exp 0 0", fetch_req, instr_valid); end
    rst_n = 1'b1;
    step();
    force_ack = 1'b0;
    total++; if (fetch_req !== 1'b1 || instr_valid !== 1'b0 || fetch_addr !== 16'h0000) begin
      bad++; $display("FAIL rm_late_ack got req=%b valid=%b addr=%h exp 1 0 0000", fetch_req, instr_valid, fetch_addr);
    end
    step();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rm_no_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [15:0] exp_pc;
    int got, first, last;
    apply_reset();
    stall_cycles = 0; instr_ready = 1'b1; mem_auto = 1'b1;
    exp_pc = 16'h0000; got = 0; first = 0; last = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      if (instr_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        total++; if (instr !== e[31:16] || instr_pc !== exp_pc) begin
          bad++; $display("FAIL b2b_item=%0d got instr=%h pc=%h exp %h %h", got, instr, instr_pc, e[31:16], exp_pc);
        end
        if (got == 0) first = cyc;
        last = cyc;
        got++;
        exp_pc = exp_pc + 16'h1;
      end
      step();
    end
    total++; if (got != 8 || last - first != 14) begin bad++; $display("FAIL b2b_rate got count=%0d span=%0d exp 8 14", got, last - first); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    apply_reset();
    goto_pc(16'hFFFF);
    stall_cycles = 0; instr_ready = 1'b1; mem_auto = 1'b1;
    for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) step();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    total++; if (instr_valid !== 1'b1 || instr !== e[31:16] || instr_pc !== 16'hFFFF) begin
      bad++; $display("FAIL wrap_deliver got valid=%b instr=%h pc=%h exp 1 %h ffff", instr_valid, instr, instr_pc, e[31:16]);
    end
`ifdef FETCH_PC_WRAP_TRAP_EN
    total++; if (trap !== 1'b1) begin bad++; $display("FAIL wrap_trap got=%b exp=1", trap); end
    step();
    mem_auto = 1'b0;
    branch_en = 1'b1; branch_addr = 16'h0100;
    step();
    branch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (fetch_req !== 1'b0 || instr_valid !== 1'b0 || trap !== 1'b1) begin
        bad++; $display("FAIL wrap_stuck got req=%b valid=%b trap=%b exp 0 0 1", fetch_req, instr_valid, trap);
      end
      step();
    end
`else
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL wrap_trap got=%b exp=0", trap); end
    step();
    total++; if (fetch_req !== 1'b1 || fetch_addr !== 16'h0000 || trap !== 1'b0) begin
      bad++; $display("FAIL wrap_next got req=%b addr=%h trap=%b exp 1 0000 0", fetch_req, fetch_addr, trap);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; branch_en = 1'b0; branch_addr = '0; instr_ready = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_backpressure();
    test_branch();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
